// File: rtl/multiple_of_n_pkg.sv
// Shared definitions for the serial divisibility checker.
//   state_t    : FSM encoding (IDLE, RUN, DONE)
//   DEF_DIV_W  : default divisor / remainder width
//   DEF_CNT_W  : default accepted-bit counter width
package multiple_of_n_pkg;

  localparam int DEF_DIV_W = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/mod2_step.sv
// One MSB-first remainder step: r_next = (2*r + b) mod d.
// Ports:
//   r      : current remainder, must be < d
//   b      : incoming bit
//   d      : divisor (d == 0 is handled by the caller)
//   r_next : updated remainder
// Because r < d, t = 2r + b < 2d, so one conditional subtract
// replaces a divider.
module mod2_step #(
  parameter int DIV_W = 8
) (
  input  logic [DIV_W-1:0] r,
  input  logic             b,
  input  logic [DIV_W-1:0] d,
  output logic [DIV_W-1:0] r_next
);

  logic [DIV_W:0]   t;
  logic [DIV_W-1:0] t_low;
  logic             ge;

  assign t     = {r, b};
  assign t_low = t[DIV_W-1:0];
  assign ge    = (t >= {1'b0, d});
  // When ge holds the true difference is < d, so it fits in DIV_W bits
  // and the modulo-2^DIV_W subtraction of the low bits is exact.
  assign r_next = ge ? (t_low - d) : t_low;

endmodule

// File: rtl/multiple_of_n_serial.sv
// Serial divisibility checker for a runtime divisor.
// Bits arrive MSB first; after every accepted bit the registered
// remainder/multiple reflect the prefix seen so far. One out_valid
// pulse is produced per frame, in the single DONE cycle.
// Handshake: a bit transfers on a rising edge where in_valid and
// in_ready are both 1; in_bit, in_last and div are only looked at on
// such a transfer. in_ready is low only in the DONE cycle (and the
// first cycle after reset).
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   in_valid/in_ready       : input handshake
//   in_bit, in_last         : serial data and end-of-frame marker
//   div                     : divisor, latched on a frame's first transfer
//   multiple, remainder     : running result for the current prefix
//   out_valid, out_multiple : per-frame result pulse
//   bit_count               : bits accepted in the frame (saturating)
//   err_div0                : frame was started with div == 0
//   dbg_state               : FSM state for observation
module multiple_of_n_serial
  import multiple_of_n_pkg::*;
#(
  parameter int DIV_W = DEF_DIV_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  input  logic [DIV_W-1:0] div,
  output logic             multiple,
  output logic [DIV_W-1:0] remainder,
  output logic             out_valid,
  output logic             out_multiple,
  output logic [CNT_W-1:0] bit_count,
  output logic             err_div0,
  output state_t           dbg_state
);

  state_t           state, state_n;
  logic [DIV_W-1:0] d_q, d_n;
  logic [DIV_W-1:0] rem_n;
  logic [CNT_W-1:0] cnt_n;
  logic             ready_n, mult_n, outv_n, outm_n, err_n;

  logic             xfer;
  logic [DIV_W-1:0] d_use, r_base, r_step, r_next;
  logic             mult_next;

  assign xfer      = in_valid && in_ready;
  assign dbg_state = state;

  // On the first bit of a frame the divisor is taken straight from the
  // port and the previous remainder is treated as 0.
  assign d_use  = (state == IDLE) ? div : d_q;
  assign r_base = (state == IDLE) ? '0 : remainder;

  mod2_step #(.DIV_W(DIV_W)) u_step (
    .r      (r_base),
    .b      (in_bit),
    .d      (d_use),
    .r_next (r_step)
  );

  // A zero divisor pins remainder and multiple at 0 for the whole frame.
  assign r_next    = (d_use == '0) ? '0 : r_step;
  assign mult_next = (d_use != '0) && (r_next == '0);

  always_comb begin
    state_n = state;
    d_n     = d_q;
    rem_n   = remainder;
    mult_n  = multiple;
    cnt_n   = bit_count;
    err_n   = err_div0;
    outv_n  = 1'b0;
    outm_n  = out_multiple;
    case (state)
      IDLE: begin
        if (xfer) begin
          d_n    = div;
          err_n  = (div == '0);
          cnt_n  = CNT_W'(1);
          rem_n  = r_next;
          mult_n = mult_next;
          if (in_last) begin
            state_n = DONE;
            outv_n  = 1'b1;
            outm_n  = mult_next;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        if (xfer) begin
          rem_n  = r_next;
          mult_n = mult_next;
          if (bit_count != '1) cnt_n = bit_count + CNT_W'(1);
          if (in_last) begin
            state_n = DONE;
            outv_n  = 1'b1;
            outm_n  = mult_next;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        rem_n   = '0;
        mult_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
    ready_n = (state_n != DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      multiple     <= 1'b0;
      remainder    <= '0;
      out_valid    <= 1'b0;
      out_multiple <= 1'b0;
      bit_count    <= '0;
      err_div0     <= 1'b0;
      d_q          <= '0;
    end else begin
      state        <= state_n;
      in_ready     <= ready_n;
      multiple     <= mult_n;
      remainder    <= rem_n;
      out_valid    <= outv_n;
      out_multiple <= outm_n;
      bit_count    <= cnt_n;
      err_div0     <= err_n;
      d_q          <= d_n;
    end
  end

endmodule
